wombat_command_master: RTL and testbench

//  Host-side initiator for the wombat UART command protocol. Converts parallel register

---
 rtl/wombat_command_master_if.sv | 31 +++
 rtl/wombat_command_master.sv | 171 +++++++++++++++++
 tb/tb_wombat_command_master.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wombat_command_master_if.sv
// Request, UART byte and response/status signals between the wombat command master and
// its host controller / UART TX-RX pair.
interface wombat_command_master_if #(
  parameter int unsigned WORD_WIDTH = 8,
  parameter int unsigned REG_WIDTH  = 4
);
  logic                            i_req_valid;
  logic                            o_req_ready;
  logic                            i_req_write;
  logic [WORD_WIDTH-1:0]           i_req_addr;
  logic [WORD_WIDTH*REG_WIDTH-1:0] i_req_data;
  logic                            o_tx_valid;
  logic                            i_tx_ready;
  logic [WORD_WIDTH-1:0]           o_tx_byte;
  logic                            i_rx_valid;
  logic [WORD_WIDTH-1:0]           i_rx_byte;
  logic                            o_rsp_valid;
  logic [WORD_WIDTH*REG_WIDTH-1:0] o_rsp_data;
  logic                            o_timeout;
  logic                            o_busy;

  modport master (
    input  i_req_valid, i_req_write, i_req_addr, i_req_data, i_tx_ready, i_rx_valid, i_rx_byte,
    output o_req_ready, o_tx_valid, o_tx_byte, o_rsp_valid, o_rsp_data, o_timeout, o_busy
  );

  modport slave (
    output i_req_valid, i_req_write, i_req_addr, i_req_data, i_tx_ready, i_rx_valid, i_rx_byte,
    input  o_req_ready, o_tx_valid, o_tx_byte, o_rsp_valid, o_rsp_data, o_timeout, o_busy
  );
endinterface

// File: rtl/wombat_command_master.sv
// Host-side initiator for the wombat UART command protocol: serialises register write/read
// requests into opcode/address/data bytes and reassembles read-response bytes into a word.
module wombat_command_master #(
  parameter int unsigned           WORD_WIDTH     = 8,
  parameter int unsigned           REG_WIDTH      = 4,
  parameter bit                    LITTLE_ENDIAN  = 1'b0,
  parameter int unsigned           TIMEOUT_CYCLES = 65536,
  parameter logic [WORD_WIDTH-1:0] OP_WRITE       = WORD_WIDTH'(8'h57),
  parameter logic [WORD_WIDTH-1:0] OP_READ        = WORD_WIDTH'(8'h52)
) (
  input logic                     clk,
  input logic                     i_reset_n,
  wombat_command_master_if.master bus
);
  localparam int unsigned DATA_W = WORD_WIDTH * REG_WIDTH;
  localparam int unsigned IDX_W  = (REG_WIDTH > 1) ? $clog2(REG_WIDTH) : 1;
  localparam int unsigned CNT_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(REG_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, SEND_OP, SEND_ADDR, SEND_DATA, WAIT_RSP} state_t;

  state_t                state_q, state_d;
  logic                  write_q, write_d;
  logic [WORD_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_W-1:0]     data_q, data_d;
  logic                  tx_valid_q, tx_valid_d;
  logic [WORD_WIDTH-1:0] tx_byte_q, tx_byte_d;
  logic [IDX_W-1:0]      idx_q, idx_d, idx_next;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_W-1:0]     asm_q, asm_d, asm_next;
  logic [DATA_W-1:0]     rsp_data_q, rsp_data_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  timeout_q, timeout_d;
  logic                  tx_fire;

  // Word k of the transmit order; MS word first unless LITTLE_ENDIAN.
  function automatic logic [WORD_WIDTH-1:0] word_at(input logic [DATA_W-1:0] d,
                                                    input logic [IDX_W-1:0]  k);
    int unsigned slot;
    slot = LITTLE_ENDIAN ? 32'(k) : (REG_WIDTH - 1 - 32'(k));
    return d[slot*WORD_WIDTH +: WORD_WIDTH];
  endfunction

  // Shifting in from the far end leaves the first byte in the right slot after REG_WIDTH bytes.
  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0]     a,
                                                 input logic [WORD_WIDTH-1:0] b);
    if (LITTLE_ENDIAN) return {b, a[DATA_W-1:WORD_WIDTH]};
    else               return {a[DATA_W-WORD_WIDTH-1:0], b};
  endfunction

  assign tx_fire  = tx_valid_q && bus.i_tx_ready;
  assign idx_next = idx_q + 1'b1;
  assign asm_next = shift_in(asm_q, bus.i_rx_byte);

  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    addr_d      = addr_q;
    data_d      = data_q;
    tx_valid_d  = tx_valid_q;
    tx_byte_d   = tx_byte_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    asm_d       = asm_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = 1'b0;
    timeout_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.i_req_valid) begin
          write_d    = bus.i_req_write;
          addr_d     = bus.i_req_addr;
          data_d     = bus.i_req_data;
          tx_valid_d = 1'b1;
          tx_byte_d  = bus.i_req_write ? OP_WRITE : OP_READ;
          state_d    = SEND_OP;
        end
      end
      SEND_OP: begin
        if (tx_fire) begin
          tx_byte_d = addr_q;
          state_d   = SEND_ADDR;
        end
      end
      SEND_ADDR: begin
        if (tx_fire) begin
          idx_d = '0;
          if (write_q) begin
            tx_byte_d = word_at(data_q, '0);
            state_d   = SEND_DATA;
          end else begin
            tx_valid_d = 1'b0;
            cnt_d      = '0;
            asm_d      = '0;
            state_d    = WAIT_RSP;
          end
        end
      end
      SEND_DATA: begin
        if (tx_fire) begin
          if (idx_q == LAST_IDX) begin
            tx_valid_d = 1'b0;
            state_d    = IDLE;
          end else begin
            idx_d     = idx_next;
            tx_byte_d = word_at(data_q, idx_next);
          end
        end
      end
      WAIT_RSP: begin
        if (bus.i_rx_valid) begin
          cnt_d = '0;
          asm_d = asm_next;
          if (idx_q == LAST_IDX) begin
            rsp_data_d  = asm_next;
            rsp_valid_d = 1'b1;
            state_d     = IDLE;
          end else begin
            idx_d = idx_next;
          end
        end else if (cnt_q == CNT_MAX) begin
          timeout_d = 1'b1;
          asm_d     = '0;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= IDLE;
      write_q     <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      tx_valid_q  <= 1'b0;
      tx_byte_q   <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      asm_q       <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      tx_valid_q  <= tx_valid_d;
      tx_byte_q   <= tx_byte_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      asm_q       <= asm_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      timeout_q   <= timeout_d;
    end
  end

  assign bus.o_req_ready = (state_q == IDLE);
  assign bus.o_busy      = (state_q != IDLE);
  assign bus.o_tx_valid  = tx_valid_q;
  assign bus.o_tx_byte   = tx_byte_q;
  assign bus.o_rsp_valid = rsp_valid_q;
  assign bus.o_rsp_data  = rsp_data_q;
  assign bus.o_timeout   = timeout_q;
endmodule

// File: tb/tb_wombat_command_master.sv
// Bench for wombat_command_master: vector table of write/read frames checked through a
// byte/response scoreboard, plus timeout, reset-abort and little-endian sequences.
`timescale 1ns/1ps
module tb_wombat_command_master;
  localparam int unsigned WW = 8;
  localparam int unsigned RW = 4;
  localparam int unsigned TO = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wombat_command_master_if #(.WORD_WIDTH(WW), .REG_WIDTH(RW)) bus ();
  wombat_command_master_if #(.WORD_WIDTH(WW), .REG_WIDTH(RW)) bus_le ();

  wombat_command_master #(
    .WORD_WIDTH(WW), .REG_WIDTH(RW), .LITTLE_ENDIAN(1'b0), .TIMEOUT_CYCLES(TO),
    .OP_WRITE(8'h57), .OP_READ(8'h52)
  ) dut (.clk(clk), .i_reset_n(rst_n), .bus(bus));

  wombat_command_master #(
    .WORD_WIDTH(WW), .REG_WIDTH(RW), .LITTLE_ENDIAN(1'b1), .TIMEOUT_CYCLES(TO),
    .OP_WRITE(8'h57), .OP_READ(8'h52)
  ) dut_le (.clk(clk), .i_reset_n(rst_n), .bus(bus_le));

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned timeout_seen = 0;
  bit          rand_mode = 1'b0;
  logic [31:0] last_rsp = '0;
  logic [7:0]  exp_tx[$];
  logic [31:0] exp_rsp[$];

  typedef struct {
    bit          wr;
    logic [7:0]  addr;
    logic [31:0] data;     // write data, or read-reply bytes in arrival order
    logic [31:0] exp_rsp;
    bit          stall;
    bit          stray;
  } vec_t;
  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  logic       prev_stall = 1'b0;
  logic [7:0] prev_byte = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("tx_hold_valid", 32'(bus.o_tx_valid), 32'd1);
        check("tx_hold_byte", 32'(bus.o_tx_byte), 32'(prev_byte));
      end
      if (bus.o_tx_valid) check("req_ready_in_frame", 32'(bus.o_req_ready), 32'd0);
      if (bus.o_tx_valid && bus.i_tx_ready) begin
        if (exp_tx.size() == 0) begin
          checks++; errors++;
          $display("FAIL tx_unexpected actual=%h required=none", bus.o_tx_byte);
        end else begin
          check("tx_byte", 32'(bus.o_tx_byte), 32'(exp_tx.pop_front()));
        end
      end
      prev_stall = bus.o_tx_valid && !bus.i_tx_ready;
      prev_byte  = bus.o_tx_byte;
      if (bus.o_rsp_valid) begin
        if (exp_rsp.size() == 0) begin
          checks++; errors++;
          $display("FAIL rsp_unexpected actual=%h required=none", bus.o_rsp_data);
        end else begin
          check("rsp_data", bus.o_rsp_data, exp_rsp.pop_front());
        end
      end
      if (bus.o_timeout) timeout_seen++;
    end
  end

  initial begin
    bus.i_tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.i_tx_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic send_req(input bit wr, input logic [7:0] addr, input logic [31:0] data);
    int unsigned g = 0;
    while (!bus.o_req_ready && g < 500) begin tick(); g++; end
    check("req_ready_wait", 32'(bus.o_req_ready), 32'd1);
    bus.i_req_valid = 1'b1;
    bus.i_req_write = wr;
    bus.i_req_addr  = addr;
    bus.i_req_data  = data;
    exp_tx.push_back(wr ? 8'h57 : 8'h52);
    exp_tx.push_back(addr);
    if (wr) for (int i = 3; i >= 0; i--) exp_tx.push_back(data[i*8 +: 8]);
    tick();
    bus.i_req_valid = 1'b0;
    bus.i_req_write = ~wr;
    bus.i_req_addr  = ~addr;
    bus.i_req_data  = ~data;
  endtask

  task automatic drain_tx(input bit stray);
    int unsigned g = 0;
    bit tog = 1'b0;
    while (exp_tx.size() != 0 && g < 500) begin
      if (stray) begin
        tog = ~tog;
        bus.i_rx_valid = tog;
        bus.i_rx_byte  = 8'($urandom);
      end
      tick();
      g++;
    end
    bus.i_rx_valid = 1'b0;
    check("tx_drain", 32'(exp_tx.size()), 32'd0);
    exp_tx.delete();
  endtask

  task automatic feed_rx(input logic [31:0] rx, input bit push, input logic [31:0] exp);
    for (int i = 3; i >= 0; i--) begin
      bus.i_rx_valid = 1'b1;
      bus.i_rx_byte  = rx[i*8 +: 8];
      if (i == 0 && push) exp_rsp.push_back(exp);
      tick();
      bus.i_rx_valid = 1'b0;
      if (i == 2) tick();
    end
  endtask

  task automatic stray_idle();
    for (int i = 0; i < 3; i++) begin
      bus.i_rx_valid = 1'b1;
      bus.i_rx_byte  = 8'($urandom);
      tick();
    end
    bus.i_rx_valid = 1'b0;
    check("stray_idle_busy", 32'(bus.o_busy), 32'd0);
  endtask

  task automatic finish_frame();
    int unsigned g = 0;
    while (bus.o_busy && g < 500) begin tick(); g++; end
    tick();
    check("idle_busy", 32'(bus.o_busy), 32'd0);
    check("idle_req_ready", 32'(bus.o_req_ready), 32'd1);
    check("rsp_q_empty", 32'(exp_rsp.size()), 32'd0);
    exp_rsp.delete();
  endtask

  initial begin
    bus.i_req_valid = 1'b0; bus.i_req_write = 1'b0; bus.i_req_addr = '0; bus.i_req_data = '0;
    bus.i_rx_valid = 1'b0; bus.i_rx_byte = '0;
    bus_le.i_req_valid = 1'b0; bus_le.i_req_write = 1'b0; bus_le.i_req_addr = '0;
    bus_le.i_req_data = '0; bus_le.i_tx_ready = 1'b1; bus_le.i_rx_valid = 1'b0;
    bus_le.i_rx_byte = '0;

    vecs[0] = '{1'b1, 8'h03, 32'hDEADBEEF, 32'h0,        1'b0, 1'b0};
    vecs[1] = '{1'b1, 8'h03, 32'hDEADBEEF, 32'h0,        1'b1, 1'b0};
    vecs[2] = '{1'b0, 8'h0A, 32'h12345678, 32'h12345678, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 8'h5C, 32'h01020304, 32'h0,        1'b1, 1'b1};
    vecs[4] = '{1'b0, 8'h7F, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 8'h00, 32'h00FF00FF, 32'h00FF00FF, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 8'hFF, 32'hFFFFFFFF, 32'h0,        1'b0, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(bus.o_req_ready), 32'd1);
    check("rst_tx_valid", 32'(bus.o_tx_valid), 32'd0);
    check("rst_tx_byte", 32'(bus.o_tx_byte), 32'd0);
    check("rst_rsp_valid", 32'(bus.o_rsp_valid), 32'd0);
    check("rst_rsp_data", bus.o_rsp_data, 32'd0);
    check("rst_timeout", 32'(bus.o_timeout), 32'd0);
    check("rst_busy", 32'(bus.o_busy), 32'd0);
    rst_n = 1'b1;
    tick();

    for (int v = 0; v < 7; v++) begin
      if (vecs[v].stray && !vecs[v].wr) stray_idle();
      rand_mode = vecs[v].stall;
      send_req(vecs[v].wr, vecs[v].addr, vecs[v].data);
      drain_tx(vecs[v].stray && vecs[v].wr);
      rand_mode = 1'b0;
      if (!vecs[v].wr) begin
        feed_rx(vecs[v].data, 1'b1, vecs[v].exp_rsp);
        last_rsp = vecs[v].exp_rsp;
      end
      finish_frame();
    end

    // Read reply stalls after two bytes: timeout fires 64 cycles after the last byte.
    begin
      int unsigned found = 0;
      int unsigned seen0 = timeout_seen;
      send_req(1'b0, 8'h21, 32'h0);
      drain_tx(1'b0);
      bus.i_rx_valid = 1'b1; bus.i_rx_byte = 8'hAA;
      tick();
      bus.i_rx_byte = 8'hBB;
      tick();
      bus.i_rx_valid = 1'b0;
      for (int k = 1; k <= 80; k++) begin
        tick();
        if (bus.o_timeout) begin found = k; break; end
      end
      check("timeout_latency", found, 32'd64);
      check("timeout_busy", 32'(bus.o_busy), 32'd0);
      check("timeout_rsp_hold", bus.o_rsp_data, last_rsp);
      tick();
      check("timeout_pulses", timeout_seen - seen0, 32'd1);
      check("timeout_strobe_low", 32'(bus.o_timeout), 32'd0);
      finish_frame();
      send_req(1'b0, 8'h22, 32'h0);
      drain_tx(1'b0);
      feed_rx(32'h0BADF00D, 1'b1, 32'h0BADF00D);
      finish_frame();
    end

    // Asynchronous reset in the middle of the data bytes.
    begin
      int unsigned g = 0;
      send_req(1'b1, 8'h44, 32'h11223344);
      while (exp_tx.size() > 3 && g < 100) begin tick(); g++; end
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_tx_valid", 32'(bus.o_tx_valid), 32'd0);
      check("arst_tx_byte", 32'(bus.o_tx_byte), 32'd0);
      check("arst_rsp_data", bus.o_rsp_data, 32'd0);
      check("arst_busy", 32'(bus.o_busy), 32'd0);
      check("arst_req_ready", 32'(bus.o_req_ready), 32'd1);
      exp_tx.delete();
      tick();
      rst_n = 1'b1;
      tick();
      send_req(1'b1, 8'h99, 32'hA5A55A5A);
      drain_tx(1'b0);
      finish_frame();
    end

    // Little-endian instance: reply bytes 12,34,56,78 assemble LS word first.
    begin
      int unsigned g = 0;
      logic [31:0] rx;
      rx = 32'h12345678;
      bus_le.i_req_valid = 1'b1;
      bus_le.i_req_write = 1'b0;
      bus_le.i_req_addr  = 8'h0A;
      tick();
      bus_le.i_req_valid = 1'b0;
      while (bus_le.o_tx_valid && g < 100) begin tick(); g++; end
      check("le_in_wait", 32'(bus_le.o_busy), 32'd1);
      for (int i = 3; i >= 0; i--) begin
        bus_le.i_rx_valid = 1'b1;
        bus_le.i_rx_byte  = rx[i*8 +: 8];
        tick();
      end
      bus_le.i_rx_valid = 1'b0;
      check("le_rsp_valid", 32'(bus_le.o_rsp_valid), 32'd1);
      check("le_rsp_data", bus_le.o_rsp_data, 32'h78563412);
      tick();
      check("le_rsp_strobe_low", 32'(bus_le.o_rsp_valid), 32'd0);
      check("le_idle", 32'(bus_le.o_busy), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end
endmodule
